// File: rtl/ddu_scan_ctrl.sv
// Debug-display controller: debounced inc/dec address stepping with auto-repeat, and 7-seg scan.
// Define DDU_LZB_EN to enable leading-zero blanking of the scanned digits.
module ddu_scan_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_CYC = 1000,
  parameter int unsigned DB_CYC   = 50000,
  parameter int unsigned RPT_DLY  = 2500000,
  parameter int unsigned RPT_CYC  = 500000,
  parameter int unsigned WRAP     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_btn,
  input  logic                  dec_btn,
  input  logic                  mem_sel,
  input  logic [4*DIGITS-1:0]   mem_data,
  input  logic [4*DIGITS-1:0]   reg_data,
  input  logic [ADDR_W-1:0]     pc,
  output logic [ADDR_W-1:0]     addr,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            hex,
  output logic [2*ADDR_W-1:0]   led,
  output logic [2:0]            rgb
);

  localparam int unsigned DATA_W  = 4 * DIGITS;
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SC_W    = $clog2(SCAN_CYC + 1);
  localparam int unsigned DB_W    = $clog2(DB_CYC + 1);
  localparam int unsigned RPT_MAX = (RPT_DLY > RPT_CYC) ? RPT_DLY : RPT_CYC;
  localparam int unsigned RP_W    = $clog2(RPT_MAX + 1);

  // Bit 0 = inc button, bit 1 = dec button.
  logic [1:0]        sync1_q, sync2_q, lvl_q, eff_prev_q, phase_q;
  logic [DB_W-1:0]   db_cnt_q  [2];
  logic [RP_W-1:0]   rpt_cnt_q [2];
  logic [1:0]        eff, rise, rpt_hit, step;
  logic [ADDR_W-1:0] addr_q, addr_up, addr_dn;

  logic [SC_W-1:0]   scan_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DIGITS-1:0] an_q, an_d, dark;
  logic [3:0]        hex_q, hex_d;
  logic [DATA_W-1:0] show;
  logic [3:0]        nibs [DIGITS];
  logic              lead_zero;

  // A button only counts while the other is released; both held suppresses stepping.
  always_comb begin
    eff[0]  = lvl_q[0] & ~lvl_q[1];
    eff[1]  = lvl_q[1] & ~lvl_q[0];
    rise    = eff & ~eff_prev_q;
    rpt_hit = '0;
    for (int b = 0; b < 2; b++) begin
      rpt_hit[b] = eff[b] & ~rise[b] &
                   (phase_q[b] ? (rpt_cnt_q[b] == RP_W'(RPT_CYC - 1))
                               : (rpt_cnt_q[b] == RP_W'(RPT_DLY - 1)));
    end
    step    = rise | rpt_hit;
    addr_up = (WRAP != 0 || addr_q != {ADDR_W{1'b1}}) ? addr_q + ADDR_W'(1) : addr_q;
    addr_dn = (WRAP != 0 || addr_q != '0) ? addr_q - ADDR_W'(1) : addr_q;
  end

  always_comb begin
    show      = mem_sel ? mem_data : reg_data;
    lead_zero = 1'b1;
    dark      = '0;
    an_d      = '1;
    for (int j = 0; j < DIGITS; j++) begin
      nibs[j]   = show[4*(DIGITS-j)-1 -: 4];
      lead_zero = lead_zero & (nibs[j] == 4'h0);
      dark[j]   = lead_zero & (j != DIGITS - 1);
      an_d[DIGITS-1-j] = (idx_q != IDX_W'(j));
    end
    hex_d = nibs[idx_q];
`ifdef DDU_LZB_EN
    if (dark[idx_q]) an_d = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      eff_prev_q <= '0;
      phase_q    <= '0;
      for (int b = 0; b < 2; b++) begin
        db_cnt_q[b]  <= '0;
        rpt_cnt_q[b] <= '0;
      end
      addr_q <= '0;
      scan_q <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      hex_q  <= '0;
    end else begin
      sync1_q    <= {dec_btn, inc_btn};
      sync2_q    <= sync1_q;
      eff_prev_q <= eff;
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] != lvl_q[b]) begin
          if (db_cnt_q[b] == DB_W'(DB_CYC - 1)) begin
            lvl_q[b]    <= sync2_q[b];
            db_cnt_q[b] <= '0;
          end else begin
            db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
          end
        end else begin
          db_cnt_q[b] <= '0;
        end
        if (!eff[b] || rise[b]) begin
          rpt_cnt_q[b] <= '0;
          phase_q[b]   <= 1'b0;
        end else if (rpt_hit[b]) begin
          rpt_cnt_q[b] <= '0;
          phase_q[b]   <= 1'b1;
        end else begin
          rpt_cnt_q[b] <= rpt_cnt_q[b] + RP_W'(1);
        end
      end
      if (step[0]) begin
        addr_q <= addr_up;
      end else if (step[1]) begin
        addr_q <= addr_dn;
      end
      if (scan_q == SC_W'(SCAN_CYC - 1)) begin
        scan_q <= '0;
        idx_q  <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        scan_q <= scan_q + SC_W'(1);
      end
      an_q  <= an_d;
      hex_q <= hex_d;
    end
  end

  assign addr = addr_q;
  assign an   = an_q;
  assign hex  = hex_q;
  assign led  = {pc, addr_q};
  assign rgb  = mem_sel ? 3'b110 : 3'b001;

endmodule

// File: tb/tb_ddu_scan_ctrl.sv
// Directed bench for ddu_scan_ctrl: scan order, debounce, auto-repeat, wrap/saturate, dual press.
module tb_ddu_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, inc_btn, dec_btn, mem_sel;
  logic [15:0] mem_data, reg_data;
  logic [7:0]  pc;
  logic [7:0]  addr, addr_s;
  logic [3:0]  an, an_s, hex, hex_s;
  logic [15:0] led, led_s;
  logic [2:0]  rgb, rgb_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddu_scan_ctrl #(
    .ADDR_W(8), .DIGITS(4), .SCAN_CYC(3), .DB_CYC(4), .RPT_DLY(20), .RPT_CYC(5), .WRAP(1)
  ) dut (
    .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn), .mem_sel(mem_sel),
    .mem_data(mem_data), .reg_data(reg_data), .pc(pc), .addr(addr), .an(an), .hex(hex),
    .led(led), .rgb(rgb)
  );

  ddu_scan_ctrl #(
    .ADDR_W(8), .DIGITS(4), .SCAN_CYC(3), .DB_CYC(4), .RPT_DLY(20), .RPT_CYC(5), .WRAP(0)
  ) dut_sat (
    .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn), .mem_sel(mem_sel),
    .mem_data(mem_data), .reg_data(reg_data), .pc(pc), .addr(addr_s), .an(an_s), .hex(hex_s),
    .led(led_s), .rgb(rgb_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    check_eq("rst_addr", 32'(addr), 32'h0);
    check_eq("rst_an", 32'(an), 32'hF);
    check_eq("rst_hex", 32'(hex), 32'h0);
    rst = 1'b0;
  endtask

  // One full scan round after reset; tables hold slot 0 (leftmost) in the top nibble.
  task automatic scan_pass(input string tag, input logic [15:0] data, input logic [15:0] an_tab,
                           input logic [15:0] hex_tab);
    reg_data = data;
    mem_sel  = 1'b0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check_eq($sformatf("%s_an%0d", tag, k), 32'(an), 32'(an_tab[15-4*(k/3) -: 4]));
      check_eq($sformatf("%s_hex%0d", tag, k), 32'(hex), 32'(hex_tab[15-4*(k/3) -: 4]));
    end
  endtask

  localparam logic [15:0] AnNormal = 16'h7BDE;
  int chk_c [11] = '{6, 7, 26, 27, 31, 32, 36, 37, 41, 42, 50};
  int chk_v [11] = '{0, 1,  1,  2,  2,  3,  3,  4,  4,  5,  5};

  initial begin
    rst      = 1'b1;
    inc_btn  = 1'b0;
    dec_btn  = 1'b0;
    mem_sel  = 1'b0;
    mem_data = 16'h5B3C;
    reg_data = 16'h1A2F;
    pc       = 8'h3C;

    // Scan order, mem_sel switch mid-digit, rgb and led.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      int s;
      logic [15:0] src;
      tick(1);
      s   = (k / 3) % 4;
      src = (k >= 17) ? mem_data : reg_data;
      check_eq($sformatf("scan_an%0d", k), 32'(an), 32'(AnNormal[15-4*s -: 4]));
      check_eq($sformatf("scan_hex%0d", k), 32'(hex), 32'(src[15-4*s -: 4]));
      if (k == 0) check_eq("rgb_reg", 32'(rgb), 32'h1);
      if (k == 16) mem_sel = 1'b1;
    end
    check_eq("rgb_mem", 32'(rgb), 32'h6);
    check_eq("led", 32'(led), 32'h3C00);

    // Glitch rejected, then one clean press steps exactly once.
    inc_btn = 1'b1;
    tick(3);
    inc_btn = 1'b0;
    tick(12);
    check_eq("glitch", 32'(addr), 32'h0);
    inc_btn = 1'b1;
    tick(6);
    check_eq("pre_press", 32'(addr), 32'h0);
    tick(1);
    check_eq("press", 32'(addr), 32'h1);
    tick(3);
    inc_btn = 1'b0;
    tick(15);
    check_eq("single_step", 32'(addr), 32'h1);
    check_eq("led_addr", 32'(led), 32'h3C01);

    // Auto-repeat: press step, then +20, +25, +30, +35 cycles.
    do_reset();
    inc_btn = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick(1);
      for (int i = 0; i < 11; i++) begin
        if (c == chk_c[i]) check_eq($sformatf("rpt_c%0d", c), 32'(addr), 32'(chk_v[i]));
      end
      if (c == 39) inc_btn = 1'b0;
    end
    check_eq("rpt_sat", 32'(addr_s), 32'h5);

    // Wrap vs saturate at both bounds.
    do_reset();
    dec_btn = 1'b1;
    tick(7);
    check_eq("wrap_dec", 32'(addr), 32'hFF);
    check_eq("sat_dec", 32'(addr_s), 32'h0);
    tick(3);
    dec_btn = 1'b0;
    tick(15);
    inc_btn = 1'b1;
    tick(7);
    check_eq("wrap_inc", 32'(addr), 32'h0);
    check_eq("sat_inc", 32'(addr_s), 32'h1);
    tick(3);
    inc_btn = 1'b0;
    tick(15);

    // Both pressed: no step; releasing dec turns inc into a fresh press.
    do_reset();
    inc_btn = 1'b1;
    dec_btn = 1'b1;
    tick(30);
    check_eq("both_held", 32'(addr), 32'h0);
    check_eq("both_held_sat", 32'(addr_s), 32'h0);
    dec_btn = 1'b0;
    tick(6);
    check_eq("both_pre", 32'(addr), 32'h0);
    tick(1);
    check_eq("both_release", 32'(addr), 32'h1);
    tick(3);
    inc_btn = 1'b0;
    tick(15);
    check_eq("both_single", 32'(addr), 32'h1);

    // Leading zeros and all-zero data.
`ifdef DDU_LZB_EN
    scan_pass("lzb", 16'h002F, 16'hFFDE, 16'h002F);
    scan_pass("zero", 16'h0000, 16'hFFFE, 16'h0000);
`else
    scan_pass("lzb", 16'h002F, AnNormal, 16'h002F);
    scan_pass("zero", 16'h0000, AnNormal, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
